// File: rtl/switch_debounce_if.sv
// Switch bundle between the raw switch inputs and the debounced lamp-logic outputs.
interface switch_debounce_if;
  logic [2:0] sw_raw;
  logic [2:0] sw_clean;
  logic [2:0] sw_rise;
  logic [2:0] sw_fall;
  logic       any_chg;

  modport master (output sw_raw, input sw_clean, input sw_rise, input sw_fall, input any_chg);
  modport slave  (input sw_raw, output sw_clean, output sw_rise, output sw_fall, output any_chg);
endinterface

// File: rtl/switch_debounce.sv
// Three independent switch debouncers: 2-flop synchronizer, mismatch counter,
// registered level plus one-cycle rise/fall pulses.
module switch_debounce #(
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  switch_debounce_if.slave sw
);

  localparam int unsigned    CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [2:0] rise_all_d;
  logic [2:0] fall_all_d;
  logic       any_chg_q;
  logic       any_chg_d;

  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      sync1_d = sw.sw_raw[gi];
      sync2_d = sync1_q;
      cnt_d   = cnt_q;
      clean_d = clean_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync2_q == clean_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        // Last of DEB_CYCLES consecutive mismatches: accept the new level.
        clean_d = sync2_q;
        cnt_d   = '0;
        rise_d  = sync2_q;
        fall_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        clean_q <= clean_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
        cnt_q   <= cnt_d;
      end
    end

    assign rise_all_d[gi]  = rise_d;
    assign fall_all_d[gi]  = fall_d;
    assign sw.sw_clean[gi] = clean_q;
    assign sw.sw_rise[gi]  = rise_q;
    assign sw.sw_fall[gi]  = fall_q;
  end

  assign any_chg_d = |(rise_all_d | fall_all_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_chg_q <= 1'b0;
    end else begin
      any_chg_q <= any_chg_d;
    end
  end

  assign sw.any_chg = any_chg_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Randomized and directed bench for switch_debounce against a sample-window reference model.
module tb_switch_debounce;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  switch_debounce_if sw_if ();

  switch_debounce #(.DEB_CYCLES(DEB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw_if)
  );

  always #5 clk = ~clk;

  // Reference: raw samples per edge; a level is accepted once the last DEB
  // samples seen through the 2-edge synchronizer delay all differ from it.
  logic [2:0] hist[$];
  logic [2:0] m_clean, m_rise, m_fall;
  logic       m_any;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] delayed(input int k);
    int idx;
    idx = hist.size() - 3 - k;
    if (idx < 0) return 3'b000;
    return hist[idx];
  endfunction

  task automatic model_reset();
    hist.delete();
    m_clean = 3'b000;
    m_rise  = 3'b000;
    m_fall  = 3'b000;
    m_any   = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] raw);
    logic all_diff;
    hist.push_back(raw);
    if (hist.size() > DEB + 2) void'(hist.pop_front());
    m_rise = 3'b000;
    m_fall = 3'b000;
    for (int ch = 0; ch < 3; ch++) begin
      all_diff = 1'b1;
      for (int k = 0; k < DEB; k++) begin
        logic [2:0] s;
        s = delayed(k);
        if (s[ch] == m_clean[ch]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_clean[ch] = ~m_clean[ch];
        m_rise[ch]  = m_clean[ch];
        m_fall[ch]  = ~m_clean[ch];
      end
    end
    m_any = |(m_rise | m_fall);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_clean"}, 32'(sw_if.sw_clean), 32'(m_clean));
    chk({tag, "_rise"},  32'(sw_if.sw_rise),  32'(m_rise));
    chk({tag, "_fall"},  32'(sw_if.sw_fall),  32'(m_fall));
    chk({tag, "_any"},   32'(sw_if.any_chg),  32'(m_any));
  endtask

  task automatic cycle(input logic [2:0] raw, input string tag);
    sw_if.sw_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input int n, input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs({tag, "_rst_async"});
    repeat (n) @(posedge clk);
    #1;
    check_outputs({tag, "_rst_hold"});
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int n_rise, n_fall, n_any;
    logic [2:0] r;
    int hold;

    sw_if.sw_raw = 3'b000;
    model_reset();
    @(posedge clk);
    #1;
    do_reset(2, "init");

    // Quiet inputs after release: nothing happens.
    for (int i = 0; i < 20; i++) cycle(3'b000, "idle");
    chk("idle_clean_final", 32'(sw_if.sw_clean), 32'd0);

    // S3 step: exact latency and pulse shape.
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      cycle(3'b100, "s3");
      if (lat == 0 && sw_if.sw_clean[2]) begin
        lat = e;
        chk("s3_rise_vec", 32'(sw_if.sw_rise), 32'b100);
        chk("s3_any", 32'(sw_if.any_chg), 32'd1);
      end
    end
    chk("s3_latency", 32'(lat), 32'(DEB + 2));
    for (int i = 0; i < 10; i++) cycle(3'b000, "s3_back");

    // S1 glitches of 3 cycles never reach the output.
    for (int p = 0; p < 4; p++)
      for (int i = 0; i < 3; i++) begin
        cycle((p % 2 == 0) ? 3'b001 : 3'b000, "s1_glitch");
        chk("s1_glitch_clean", 32'(sw_if.sw_clean[0]), 32'd0);
      end
    for (int i = 0; i < 10; i++) cycle(3'b000, "s1_settle");

    // Two channels together, up then down.
    n_rise = 0; n_fall = 0; n_any = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(3'b011, "s12_up");
      if (sw_if.sw_rise != 3'b000) begin n_rise++; chk("s12_rise_vec", 32'(sw_if.sw_rise), 32'b011); end
      if (sw_if.any_chg) n_any++;
    end
    for (int i = 0; i < 12; i++) begin
      cycle(3'b000, "s12_dn");
      if (sw_if.sw_fall != 3'b000) begin n_fall++; chk("s12_fall_vec", 32'(sw_if.sw_fall), 32'b011); end
      if (sw_if.any_chg) n_any++;
    end
    chk("s12_rise_count", 32'(n_rise), 32'd1);
    chk("s12_fall_count", 32'(n_fall), 32'd1);
    chk("s12_any_count", 32'(n_any), 32'd2);

    // S2 step interrupted by reset, input still high at release.
    for (int i = 0; i < 3; i++) cycle(3'b010, "s2_pre");
    do_reset(2, "s2");
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      cycle(3'b010, "s2_post");
      if (lat == 0 && sw_if.sw_clean[1]) begin
        lat = e;
        chk("s2_rise_vec", 32'(sw_if.sw_rise), 32'b010);
      end
    end
    chk("s2_latency", 32'(lat), 32'(DEB + 2));
    for (int i = 0; i < 10; i++) cycle(3'b000, "s2_back");

    // Random bouncing with occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      r = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 8);
      if ($urandom_range(0, 49) == 0) do_reset($urandom_range(1, 3), "rnd");
      for (int i = 0; i < hold; i++) cycle(r, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
